sva_result_monitor: RTL and testbench

- Sits directly downstream of the SVA FSM checker and consumes its per-evaluation verdict flags (succ, fail, lazy_succ).
- Keeps saturating verdict counters and captures the timestamp of the first failure.
- Logs timestamped verdict events into a small FIFO that a reader drains through a valid/ready port.
- A run-control FSM can halt logging on the first failure, so the bench or debug logic can freeze state.

---
 rtl/sva_result_pkg.sv | 44 ++++
 rtl/sva_evt_fifo.sv | 92 +++++++++
 rtl/sva_result_monitor.sv | 188 ++++++++++++++++++
 tb/tb_sva_result_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sva_result_pkg.sv
// Shared types for the SVA result monitor: verdict event kinds, run-control
// states, the default-width event record and the verdict-to-kind priority.
package sva_result_pkg;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_SUCC = 2'd1,
        EVT_FAIL = 2'd2,
        EVT_LAZY = 2'd3
    } evt_kind_t;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_HALT = 2'd2
    } mon_state_t;

    // Default timestamp width. Modules with a different TS_WIDTH declare the
    // same {kind, ts} layout locally at their own width.
    localparam int unsigned EVT_TS_WIDTH_DEF = 32;

    typedef struct packed {
        evt_kind_t                   kind;
        logic [EVT_TS_WIDTH_DEF-1:0] ts;
    } sva_evt_t;

    // One event per evaluation: fail outranks succ, and succ outranks lazy.
    function automatic evt_kind_t evt_kind_sel(input logic succ_f,
                                               input logic fail_f,
                                               input logic lazy_f);
        evt_kind_t kind;
        if (fail_f) begin
            kind = EVT_FAIL;
        end else if (succ_f) begin
            kind = EVT_SUCC;
        end else if (lazy_f) begin
            kind = EVT_LAZY;
        end else begin
            kind = EVT_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sva_evt_fifo.sv
// Event FIFO with a registered head word and a valid/ready read port.
// The head register is loaded with whatever becomes the head at each edge,
// so a push into an empty FIFO shows up as valid one cycle later and the
// head is stable while the reader stalls.
module sva_evt_fifo #(
    parameter int unsigned DATA_WIDTH = 34,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  valid_q, valid_d;
    logic                  full;
    logic                  pop;
    logic                  push_ok;

    // Full when the wrap bits differ but the slot indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = valid_q && rd_ready_i;
    // A push into a full FIFO only fits when the head leaves in the same cycle.
    assign push_ok = push_i && !flush_i && (!full || pop);

    // Next pointers and the word that will sit at the head after this edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        valid_d = (wr_ptr_d != rd_ptr_d);
        head_d  = '0;
        if (valid_d) begin
            // The incoming word becomes the head when it lands in the head slot.
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointers and head register; flush empties the FIFO in one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign full_o     = full;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = head_q;

endmodule

// File: rtl/sva_result_monitor.sv
// Verdict monitor downstream of the SVA checker: saturating verdict counters,
// first-fail capture, a free-running timestamp and a timestamped event log,
// under a small IDLE/RUN/HALT run-control FSM.
module sva_result_monitor #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned TS_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  res_valid,
    input  logic                  succ,
    input  logic                  fail,
    input  logic                  lazy_succ,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [TS_WIDTH+1:0]   evt_data,
    output logic [CNT_WIDTH-1:0]  succ_cnt,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [CNT_WIDTH-1:0]  lazy_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  first_fail_vld,
    output logic [TS_WIDTH-1:0]   first_fail_ts,
    output logic                  running,
    output logic                  halted,
    output logic                  overflow
);

    import sva_result_pkg::*;

    typedef struct packed {
        evt_kind_t           kind;
        logic [TS_WIDTH-1:0] ts;
    } evt_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TS_WIDTH-1:0]  TS_ONE   = {{(TS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                 HALT_ENA = (STOP_ON_FAIL != 0);

    mon_state_t            state_q;
    logic                  running_q;
    logic                  halted_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;
    logic                  overflow_q;
    logic                  first_fail_vld_q;
    logic [TS_WIDTH-1:0]   first_fail_ts_q;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic [2:0]            hit;
    logic [3*CNT_WIDTH-1:0] cnt_all;
    evt_t                  evt_wdata;

    // Verdicts only count in RUN, and a simultaneous clear discards them.
    assign accept = res_valid && (state_q == MON_RUN) && !clear;
    assign push   = accept && (succ || fail || lazy_succ);
    assign pop    = evt_valid && evt_ready;
    assign drop   = push && fifo_full && !pop;
    assign hit    = {lazy_succ, fail, succ} & {3{accept}};

    assign evt_wdata.kind = evt_kind_sel(succ, fail, lazy_succ);
    assign evt_wdata.ts   = ts_q;

    // Run-control FSM with registered status outputs; clear beats start.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= MON_IDLE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else if (clear) begin
            state_q   <= MON_IDLE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                MON_IDLE: begin
                    if (start) begin
                        state_q   <= MON_RUN;
                        running_q <= 1'b1;
                    end
                end
                MON_RUN: begin
                    if (accept && fail && HALT_ENA) begin
                        state_q   <= MON_HALT;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                MON_HALT: begin
                    state_q <= MON_HALT;
                end
                default: begin
                    state_q   <= MON_IDLE;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    // Timestamp advances only while running and wraps naturally.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q <= '0;
        end else if (clear) begin
            ts_q <= '0;
        end else if (state_q == MON_RUN) begin
            ts_q <= ts_q + TS_ONE;
        end
    end

    // One saturating counter per verdict flag: 0 = succ, 1 = fail, 2 = lazy.
    for (genvar gi = 0; gi < 3; gi++) begin : g_verdict_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        // Count accepted verdicts of this kind, holding at all-ones.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_q <= '0;
            end else if (clear) begin
                cnt_q <= '0;
            end else if (hit[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end

        assign cnt_all[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

    // Drop accounting and first-fail capture; both are sticky until clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt_q       <= '0;
            overflow_q       <= 1'b0;
            first_fail_vld_q <= 1'b0;
            first_fail_ts_q  <= '0;
        end else if (clear) begin
            drop_cnt_q       <= '0;
            overflow_q       <= 1'b0;
            first_fail_vld_q <= 1'b0;
            first_fail_ts_q  <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + CNT_ONE;
                end
            end
            if (accept && fail && !first_fail_vld_q) begin
                first_fail_vld_q <= 1'b1;
                first_fail_ts_q  <= ts_q;
            end
        end
    end

    sva_evt_fifo #(
        .DATA_WIDTH (TS_WIDTH + 2),
        .DEPTH      (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .flush_i    (clear),
        .push_i     (push),
        .wdata_i    (evt_wdata),
        .full_o     (fifo_full),
        .rd_valid_o (evt_valid),
        .rd_ready_i (evt_ready),
        .rd_data_o  (evt_data)
    );

    assign succ_cnt       = cnt_all[0*CNT_WIDTH +: CNT_WIDTH];
    assign fail_cnt       = cnt_all[1*CNT_WIDTH +: CNT_WIDTH];
    assign lazy_cnt       = cnt_all[2*CNT_WIDTH +: CNT_WIDTH];
    assign drop_cnt       = drop_cnt_q;
    assign overflow       = overflow_q;
    assign first_fail_vld = first_fail_vld_q;
    assign first_fail_ts  = first_fail_ts_q;
    assign running        = running_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_sva_result_monitor.sv
// Directed bench for sva_result_monitor: instance A uses the defaults
// (16-bit counters, depth 8, stop on fail); instance B uses 4-bit counters,
// depth 4 and keeps running after a fail.
module tb_sva_result_monitor;

    logic clk;
    logic rst_n;

    // Instance A
    logic        start_a, clear_a, rv_a, succ_a, fail_a, lazy_a, ready_a;
    logic        evt_valid_a;
    logic [33:0] evt_data_a;
    logic [15:0] succ_cnt_a, fail_cnt_a, lazy_cnt_a, drop_cnt_a;
    logic        ffv_a, running_a, halted_a, overflow_a;
    logic [31:0] ffts_a;

    // Instance B
    logic        start_b, clear_b, rv_b, succ_b, fail_b, lazy_b, ready_b;
    logic        evt_valid_b;
    logic [33:0] evt_data_b;
    logic [3:0]  succ_cnt_b, fail_cnt_b, lazy_cnt_b, drop_cnt_b;
    logic        ffv_b, running_b, halted_b, overflow_b;
    logic [31:0] ffts_b;

    int checks;
    int failures;

    sva_result_monitor #(
        .CNT_WIDTH(16), .TS_WIDTH(32), .FIFO_DEPTH(8), .STOP_ON_FAIL(1)
    ) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a), .clear(clear_a),
        .res_valid(rv_a), .succ(succ_a), .fail(fail_a), .lazy_succ(lazy_a),
        .evt_valid(evt_valid_a), .evt_ready(ready_a), .evt_data(evt_data_a),
        .succ_cnt(succ_cnt_a), .fail_cnt(fail_cnt_a), .lazy_cnt(lazy_cnt_a),
        .drop_cnt(drop_cnt_a), .first_fail_vld(ffv_a), .first_fail_ts(ffts_a),
        .running(running_a), .halted(halted_a), .overflow(overflow_a)
    );

    sva_result_monitor #(
        .CNT_WIDTH(4), .TS_WIDTH(32), .FIFO_DEPTH(4), .STOP_ON_FAIL(0)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b), .clear(clear_b),
        .res_valid(rv_b), .succ(succ_b), .fail(fail_b), .lazy_succ(lazy_b),
        .evt_valid(evt_valid_b), .evt_ready(ready_b), .evt_data(evt_data_b),
        .succ_cnt(succ_cnt_b), .fail_cnt(fail_cnt_b), .lazy_cnt(lazy_cnt_b),
        .drop_cnt(drop_cnt_b), .first_fail_vld(ffv_b), .first_fail_ts(ffts_b),
        .running(running_b), .halted(halted_b), .overflow(overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, got);
        end
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic clear_pulse_a();
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
    endtask

    task automatic push_a(input logic s, input logic f, input logic l, input int n);
        rv_a = 1'b1; succ_a = s; fail_a = f; lazy_a = l;
        repeat (n) tick();
        rv_a = 1'b0; succ_a = 1'b0; fail_a = 1'b0; lazy_a = 1'b0;
    endtask

    // Check the head of A's FIFO against {kind, ts}, then pop it.
    task automatic pop_expect_a(input string tag, input logic [1:0] kind, input logic [31:0] ts);
        logic [33:0] exp;
        exp = {kind, ts};
        check_eq({tag, "_valid"}, {63'd0, evt_valid_a}, 64'd1);
        check_eq({tag, "_data"}, {30'd0, evt_data_a}, {30'd0, exp});
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        {start_a, clear_a, rv_a, succ_a, fail_a, lazy_a, ready_a} = '0;
        {start_b, clear_b, rv_b, succ_b, fail_b, lazy_b, ready_b} = '0;
        repeat (2) tick();

        // Reset values
        check_eq("rst_evt_valid", {63'd0, evt_valid_a}, 64'd0);
        check_eq("rst_evt_data", {30'd0, evt_data_a}, 64'd0);
        check_eq("rst_succ_cnt", {48'd0, succ_cnt_a}, 64'd0);
        check_eq("rst_running", {63'd0, running_a}, 64'd0);
        check_eq("rst_halted", {63'd0, halted_a}, 64'd0);
        check_eq("rst_overflow", {63'd0, overflow_a}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Three succ verdicts at ts 0,1,2
        start_pulse_a();
        check_eq("t1_running", {63'd0, running_a}, 64'd1);
        push_a(1'b1, 1'b0, 1'b0, 3);
        check_eq("t1_succ_cnt", {48'd0, succ_cnt_a}, 64'd3);
        pop_expect_a("t1_evt0", 2'd1, 32'd0);
        pop_expect_a("t1_evt1", 2'd1, 32'd1);
        pop_expect_a("t1_evt2", 2'd1, 32'd2);
        check_eq("t1_empty", {63'd0, evt_valid_a}, 64'd0);

        // Stop on fail: succ at ts 4, fail at ts 7, later verdicts ignored
        clear_pulse_a();
        check_eq("clr_succ_cnt", {48'd0, succ_cnt_a}, 64'd0);
        start_pulse_a();
        repeat (4) tick();
        push_a(1'b1, 1'b0, 1'b0, 1);
        repeat (2) tick();
        push_a(1'b0, 1'b1, 1'b0, 1);
        push_a(1'b1, 1'b1, 1'b1, 3);
        check_eq("t2_fail_cnt", {48'd0, fail_cnt_a}, 64'd1);
        check_eq("t2_succ_cnt", {48'd0, succ_cnt_a}, 64'd1);
        check_eq("t2_lazy_cnt", {48'd0, lazy_cnt_a}, 64'd0);
        check_eq("t2_ff_vld", {63'd0, ffv_a}, 64'd1);
        check_eq("t2_ff_ts", {32'd0, ffts_a}, 64'd7);
        check_eq("t2_halted", {63'd0, halted_a}, 64'd1);
        check_eq("t2_running", {63'd0, running_a}, 64'd0);
        pop_expect_a("t2_evt0", 2'd1, 32'd4);
        pop_expect_a("t2_evt1", 2'd2, 32'd7);
        check_eq("t2_empty", {63'd0, evt_valid_a}, 64'd0);

        // succ and fail together: one kind-2 event, both counted
        clear_pulse_a();
        start_pulse_a();
        push_a(1'b1, 1'b1, 1'b0, 1);
        check_eq("t3_succ_cnt", {48'd0, succ_cnt_a}, 64'd1);
        check_eq("t3_fail_cnt", {48'd0, fail_cnt_a}, 64'd1);
        check_eq("t3_halted", {63'd0, halted_a}, 64'd1);
        pop_expect_a("t3_evt0", 2'd2, 32'd0);
        check_eq("t3_empty", {63'd0, evt_valid_a}, 64'd0);

        // Ten pushes into depth 8 with the reader stalled
        clear_pulse_a();
        start_pulse_a();
        push_a(1'b1, 1'b0, 1'b0, 10);
        check_eq("t4_drop_cnt", {48'd0, drop_cnt_a}, 64'd2);
        check_eq("t4_overflow", {63'd0, overflow_a}, 64'd1);
        check_eq("t4_succ_cnt", {48'd0, succ_cnt_a}, 64'd10);
        check_eq("t4_head_hold", {30'd0, evt_data_a}, {30'd0, 2'd1, 32'd0});
        // Push while full with a simultaneous pop: no new drop
        rv_a = 1'b1; succ_a = 1'b1; ready_a = 1'b1;
        tick();
        rv_a = 1'b0; succ_a = 1'b0; ready_a = 1'b0;
        check_eq("t4_drop_pp", {48'd0, drop_cnt_a}, 64'd2);
        tick();
        for (int i = 1; i <= 7; i++) begin
            pop_expect_a($sformatf("t4_evt%0d", i), 2'd1, i);
        end
        pop_expect_a("t4_evt_last", 2'd1, 32'd10);
        check_eq("t4_empty", {63'd0, evt_valid_a}, 64'd0);

        // clear together with start and res_valid mid-run
        clear_pulse_a();
        start_pulse_a();
        push_a(1'b1, 1'b0, 1'b1, 2);
        clear_a = 1'b1; start_a = 1'b1; rv_a = 1'b1; succ_a = 1'b1;
        tick();
        clear_a = 1'b0; start_a = 1'b0; rv_a = 1'b0; succ_a = 1'b0;
        check_eq("t5_running", {63'd0, running_a}, 64'd0);
        check_eq("t5_succ_cnt", {48'd0, succ_cnt_a}, 64'd0);
        check_eq("t5_lazy_cnt", {48'd0, lazy_cnt_a}, 64'd0);
        check_eq("t5_evt_valid", {63'd0, evt_valid_a}, 64'd0);
        tick();
        check_eq("t5_still_idle", {63'd0, running_a}, 64'd0);
        start_pulse_a();
        push_a(1'b0, 1'b0, 1'b1, 1);
        pop_expect_a("t5_ts_zeroed", 2'd3, 32'd0);

        // Instance B: 4-bit saturation, keep running after fail
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        rv_b = 1'b1; succ_b = 1'b1;
        repeat (20) tick();
        succ_b = 1'b0; fail_b = 1'b1;
        repeat (2) tick();
        rv_b = 1'b0; fail_b = 1'b0;
        check_eq("b_succ_sat", {60'd0, succ_cnt_b}, 64'd15);
        check_eq("b_drop_sat", {60'd0, drop_cnt_b}, 64'd15);
        check_eq("b_fail_cnt", {60'd0, fail_cnt_b}, 64'd2);
        check_eq("b_ff_ts", {32'd0, ffts_b}, 64'd20);
        check_eq("b_running", {63'd0, running_b}, 64'd1);
        check_eq("b_halted", {63'd0, halted_b}, 64'd0);
        check_eq("b_overflow", {63'd0, overflow_b}, 64'd1);
        check_eq("b_head", {30'd0, evt_data_b}, {30'd0, 2'd1, 32'd0});

        // Asynchronous reset between clock edges
        push_a(1'b1, 1'b0, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_succ_cnt", {48'd0, succ_cnt_a}, 64'd0);
        check_eq("ar_running", {63'd0, running_a}, 64'd0);
        check_eq("ar_evt_valid", {63'd0, evt_valid_a}, 64'd0);
        check_eq("ar_evt_data", {30'd0, evt_data_a}, 64'd0);
        check_eq("ar_b_succ", {60'd0, succ_cnt_b}, 64'd0);
        check_eq("ar_b_ffv", {63'd0, ffv_b}, 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check_eq("ar_idle_after", {63'd0, running_a}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
